// File: rtl/xnor_conv_seq_ctrl_pkg.sv
// Shared types and constants for the XNOR convolution sequencer.
// Holds the FSM state encoding, the default job geometry and a width
// helper so that counters and index ports never collapse to zero bits.
package xnor_conv_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_FILL,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_K          = 3;
    localparam int DEF_IMG_W      = 8;
    localparam int DEF_IMG_H      = 8;
    localparam int DEF_PSUM_WIDTH = 4;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xnor_conv_seq_ctrl_if.sv
// Job, weight and activation handshakes between the layer scheduler
// (master) and the convolution sequencer (slave).
//   cmd_valid/cmd_ready : job request / controller idle
//   wgt_valid/wgt_ready : one weight bit per accepted beat
//   act_valid/act_ready : one activation column per accepted beat
interface xnor_conv_seq_ctrl_if;

    logic cmd_valid;
    logic cmd_ready;
    logic wgt_valid;
    logic wgt_ready;
    logic act_valid;
    logic act_ready;

    modport master (
        output cmd_valid, wgt_valid, act_valid,
        input  cmd_ready, wgt_ready, act_ready
    );

    modport slave (
        input  cmd_valid, wgt_valid, act_valid,
        output cmd_ready, wgt_ready, act_ready
    );

endinterface

// File: rtl/xnor_conv_seq_ctrl_wrap_counter.sv
// Up-counter that wraps to zero after LIMIT.
//   clk, rst : clock and synchronous active-high reset
//   en       : advance by one (wraps to 0 when tc is high)
//   clear    : force to zero, takes priority over en
//   count    : current value
//   tc       : high while count == LIMIT
module xnor_conv_seq_ctrl_wrap_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT);

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/xnor_conv_seq_ctrl.sv
// Sequencer for a row of XNOR_CONV_PE cells running one binary KxK
// convolution job: accepts a job, loads K*K weight bits, streams the
// activation rows and flags every valid partial-sum beat.
//   clk, rst        : clock and synchronous active-high reset
//   hs              : cmd/wgt/act handshakes (slave side)
//   en              : PE array enable
//   weight_control  : PE weight shift-load
//   top_start       : first beat of a row
//   top_control     : select the top input path
//   start           : PE accumulate and emit psum
//   side_control    : select the horizontal-reuse input path
//   out_valid       : array pcountout valid this cycle
//   row_idx/col_idx : current output row / activation column
//   busy            : job in progress
//   done            : one-cycle job-complete pulse
module xnor_conv_seq_ctrl
    import xnor_conv_seq_ctrl_pkg::*;
#(
    parameter int K          = DEF_K,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    xnor_conv_seq_ctrl_if.slave           hs,
    output logic                          en,
    output logic                          weight_control,
    output logic                          top_start,
    output logic                          top_control,
    output logic                          start,
    output logic                          side_control,
    output logic                          out_valid,
    output logic [clog2_min1(IMG_H)-1:0]  row_idx,
    output logic [clog2_min1(IMG_W)-1:0]  col_idx,
    output logic                          busy,
    output logic                          done
);

    localparam int WCNT_W    = clog2_min1(K * K);
    localparam int ROW_W     = clog2_min1(IMG_H);
    localparam int COL_W     = clog2_min1(IMG_W);
    localparam int FILL_LAST = (K >= 2) ? K - 2 : 0;

    localparam logic [WCNT_W-1:0] DRAIN_LAST    = WCNT_W'(K - 1);
    localparam logic [COL_W-1:0]  COL_FILL_LAST = COL_W'(FILL_LAST);
    localparam logic [COL_W:0]    COL_SIDE_MIN  = (COL_W + 1)'(K);
    localparam state_t            ROW_START     = (K == 1) ? ST_STREAM : ST_FILL;

    if (K < 1 || IMG_W < K || IMG_H < K || PSUM_WIDTH < 1) begin : g_bad_params
        $error("xnor_conv_seq_ctrl: illegal geometry");
    end

    state_t              state;
    logic [WCNT_W-1:0]   wcnt;
    logic                wcnt_tc;
    logic                col_tc;
    logic                row_tc;
    logic                cmd_fire;
    logic                wgt_open;
    logic                act_open;
    logic                wgt_fire;
    logic                act_fire;
    logic                drain_exit;
    logic                row_step;

    assign wgt_open = (state == ST_LOAD_W);
    assign act_open = (state == ST_FILL) || (state == ST_STREAM);

    assign hs.cmd_ready = (state == ST_IDLE);
    assign hs.wgt_ready = wgt_open;
    assign hs.act_ready = act_open;

    assign cmd_fire   = (state == ST_IDLE) && hs.cmd_valid;
    assign wgt_fire   = wgt_open && hs.wgt_valid;
    assign act_fire   = act_open && hs.act_valid;
    assign drain_exit = (state == ST_DRAIN) && (wcnt == DRAIN_LAST);
    // The last row ends the image, so row_idx stays put and DRAIN follows.
    assign row_step   = act_fire && col_tc && !row_tc;

    // wcnt counts weight beats, then is reused to time the K drain cycles;
    // it never reaches K*K-1 in DRAIN, so it is cleared on the way out.
    xnor_conv_seq_ctrl_wrap_counter #(
        .WIDTH (WCNT_W),
        .LIMIT (K * K - 1)
    ) u_wcnt (
        .clk   (clk),
        .rst   (rst),
        .en    (wgt_fire || (state == ST_DRAIN)),
        .clear (cmd_fire || drain_exit),
        .count (wcnt),
        .tc    (wcnt_tc)
    );

    xnor_conv_seq_ctrl_wrap_counter #(
        .WIDTH (COL_W),
        .LIMIT (IMG_W - 1)
    ) u_col (
        .clk   (clk),
        .rst   (rst),
        .en    (act_fire),
        .clear (cmd_fire),
        .count (col_idx),
        .tc    (col_tc)
    );

    xnor_conv_seq_ctrl_wrap_counter #(
        .WIDTH (ROW_W),
        .LIMIT (IMG_H - K)
    ) u_row (
        .clk   (clk),
        .rst   (rst),
        .en    (row_step),
        .clear (cmd_fire),
        .count (row_idx),
        .tc    (row_tc)
    );

    // PE controls are only raised on a cycle that actually moves a beat,
    // so a stalled cycle leaves the array frozen.
    always_comb begin
        en             = 1'b0;
        weight_control = 1'b0;
        top_start      = 1'b0;
        top_control    = 1'b0;
        start          = 1'b0;
        side_control   = 1'b0;
        case (state)
            ST_LOAD_W: begin
                if (wgt_fire) begin
                    en             = 1'b1;
                    weight_control = 1'b1;
                end
            end
            ST_FILL: begin
                if (act_fire) begin
                    en          = 1'b1;
                    top_control = 1'b1;
                    top_start   = (col_idx == '0);
                end
            end
            ST_STREAM: begin
                if (act_fire) begin
                    en           = 1'b1;
                    start        = 1'b1;
                    top_control  = 1'b1;
                    side_control = ({1'b0, col_idx} >= COL_SIDE_MIN);
                    top_start    = (K == 1) && (col_idx == '0);
                end
            end
            ST_DRAIN: begin
                en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Job FSM with its registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == ST_STREAM) && act_fire;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hs.cmd_valid) begin
                        state <= ST_LOAD_W;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD_W: begin
                    if (wgt_fire && wcnt_tc) begin
                        state <= ROW_START;
                    end
                end
                ST_FILL: begin
                    if (act_fire && (col_idx == COL_FILL_LAST)) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (act_fire && col_tc) begin
                        state <= row_tc ? ST_DRAIN : ROW_START;
                    end
                end
                ST_DRAIN: begin
                    if (drain_exit) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
